// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-requester BRAM arbiter.
// Arbitration policy is selected with the BRAM_ARB_RR_EN macro (see bram_arbiter).
package bram_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned WE_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/bram_arb_rr.sv
// Tie-break for two requesters: a sole requester wins, on a tie the one not
// granted last wins. Pure combinational, no state.
module bram_arb_rr
  import bram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_valid,
  input  req_id_t            i_last,
  output logic [NUM_REQ-1:0] o_grant_c
);

  always_comb begin
    o_grant_c = '0;
    case (i_valid)
      2'b01:   o_grant_c = 2'b01;
      2'b10:   o_grant_c = 2'b10;
      2'b11:   o_grant_c = i_last ? 2'b01 : 2'b10;
      default: o_grant_c = '0;
    endcase
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM with burst locking.
// BRAM_ARB_RR_EN defined: round-robin ties in IDLE; undefined: requester 0 has priority.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_lock,
  input  logic [WE_W-1:0]      req0_we,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [DATA_SIZE-1:0] req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_lock,
  input  logic [WE_W-1:0]      req1_we,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [DATA_SIZE-1:0] req1_wdata,
  output logic                 rsp0_valid,
  output logic [DATA_SIZE-1:0] rsp0_rdata,
  output logic                 rsp1_valid,
  output logic [DATA_SIZE-1:0] rsp1_rdata,
  output logic                 bram_en,
  output logic [WE_W-1:0]      bram_we,
  output logic [ADDR_SIZE-1:0] bram_addr,
  output logic [DATA_SIZE-1:0] bram_din,
  input  logic [DATA_SIZE-1:0] bram_dout
);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [NUM_REQ-1:0]   w_valid;
  logic [NUM_REQ-1:0]   w_tie_grant;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_acc;
  req_id_t              w_acc_id;
  req_id_t              w_last;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic                 r_rsp_wr;
  logic [DATA_SIZE-1:0] r_rsp_wdata;
  logic [DATA_SIZE-1:0] w_rsp_data;

  assign w_valid  = {req1_valid, req0_valid};
  assign w_acc    = |w_grant;
  assign w_acc_id = req_id_t'(w_grant[1]);

`ifdef BRAM_ARB_RR_EN
  req_id_t r_last;

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_acc) begin
      r_last <= w_acc_id;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = 1'b1;
`endif

  bram_arb_rr u_rr (
    .i_valid   (w_valid),
    .i_last    (w_last),
    .o_grant_c (w_tie_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant and next state; the lock owner is the only candidate while locked.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = '0;
    unique case (r_state)
      IDLE: begin
        w_grant = w_tie_grant;
        if (w_grant[0] && req0_lock) begin
          w_state_nxt = LOCK0;
        end else if (w_grant[1] && req1_lock) begin
          w_state_nxt = LOCK1;
        end
      end
      LOCK0: begin
        w_grant = {1'b0, req0_valid};
        if (req0_valid && !req0_lock) begin
          w_state_nxt = IDLE;
        end
      end
      LOCK1: begin
        w_grant = {req1_valid, 1'b0};
        if (req1_valid && !req1_lock) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      w_grant = '0;
    end
  end

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  always_comb begin
    bram_en   = w_acc;
    bram_we   = '0;
    bram_addr = '0;
    bram_din  = '0;
    if (w_grant[0]) begin
      bram_we   = req0_we;
      bram_addr = req0_addr;
      bram_din  = req0_wdata;
    end else if (w_grant[1]) begin
      bram_we   = req1_we;
      bram_addr = req1_addr;
      bram_din  = req1_wdata;
    end
  end

  // Response tracks the accept one cycle later; writes echo their own data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_wr    <= 1'b0;
      r_rsp_wdata <= '0;
    end else begin
      r_rsp_valid <= w_grant;
      if (w_acc) begin
        r_rsp_wr    <= |bram_we;
        r_rsp_wdata <= bram_din;
      end
    end
  end

  assign w_rsp_data = r_rsp_wr ? r_rsp_wdata : bram_dout;
  assign rsp0_valid = r_rsp_valid[0];
  assign rsp1_valid = r_rsp_valid[1];
  assign rsp0_rdata = r_rsp_valid[0] ? w_rsp_data : '0;
  assign rsp1_rdata = r_rsp_valid[1] ? w_rsp_data : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: a BRAM stand-in, a reference model of
// the arbitration/lock/response rules, and directed scenarios with literal checks.
`timescale 1ns/1ps
module tb_bram_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_lock;
  logic [3:0]    req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_lock;
  logic [3:0]    req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din, bram_dout;

  bram_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock),
    .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lock(req1_lock),
    .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  // BRAM stand-in: 1-cycle read latency, write-first, byte enables.
  logic [DW-1:0] bram_mem [DEPTH];
  always @(posedge clk) begin
    logic [DW-1:0] w;
    if (bram_en) begin
      w = bram_mem[bram_addr];
      for (int b = 0; b < 4; b++) if (bram_we[b]) w[8*b +: 8] = bram_din[8*b +: 8];
      bram_mem[bram_addr] = w;
      bram_dout <= w;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_owner;
  int            m_last;
  logic [1:0]    m_rv;
  logic [DW-1:0] m_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: checks this cycle's outputs, then commits the accept.
  task automatic model_step();
    int            g;
    logic [3:0]    we;
    logic [AW-1:0] a;
    logic [DW-1:0] d, w;
    logic          lk;
    if (!rst_n) begin
      chk("rst_ready0", 64'(req0_ready), 64'h0);
      chk("rst_ready1", 64'(req1_ready), 64'h0);
      chk("rst_en",     64'(bram_en),    64'h0);
      chk("rst_rsp0",   64'(rsp0_valid), 64'h0);
      chk("rst_rsp1",   64'(rsp1_valid), 64'h0);
      chk("rst_rdata",  64'(rsp0_rdata | rsp1_rdata), 64'h0);
      m_owner = -1;
      m_last  = 1;
      m_rv    = '0;
      m_rd    = '0;
      return;
    end
    if (m_owner >= 0) begin
      g = ((m_owner == 0) ? req0_valid : req1_valid) ? m_owner : -1;
    end else if (req0_valid && req1_valid) begin
`ifdef BRAM_ARB_RR_EN
      g = (m_last == 0) ? 1 : 0;
`else
      g = 0;
`endif
    end else if (req0_valid) g = 0;
    else if (req1_valid) g = 1;
    else g = -1;

    we = '0; a = '0; d = '0; lk = 1'b0;
    if (g == 0) begin we = req0_we; a = req0_addr; d = req0_wdata; lk = req0_lock; end
    if (g == 1) begin we = req1_we; a = req1_addr; d = req1_wdata; lk = req1_lock; end

    chk("ready0",    64'(req0_ready), 64'(g == 0));
    chk("ready1",    64'(req1_ready), 64'(g == 1));
    chk("bram_en",   64'(bram_en),    64'(g >= 0));
    chk("bram_we",   64'(bram_we),    64'(we));
    chk("bram_addr", 64'(bram_addr),  64'(a));
    chk("bram_din",  64'(bram_din),   64'(d));
    chk("rsp0_valid", 64'(rsp0_valid), 64'(m_rv[0]));
    chk("rsp1_valid", 64'(rsp1_valid), 64'(m_rv[1]));
    chk("rsp0_rdata", 64'(rsp0_rdata), 64'(m_rv[0] ? m_rd : '0));
    chk("rsp1_rdata", 64'(rsp1_rdata), 64'(m_rv[1] ? m_rd : '0));

    if (g >= 0) begin
      w = m_mem[a];
      for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = d[8*b +: 8];
      m_mem[a] = w;
      m_rd     = (we != 4'h0) ? d : w;
      m_rv     = (g == 0) ? 2'b01 : 2'b10;
      m_owner  = lk ? g : -1;
      m_last   = g;
    end else begin
      m_rv = '0;
    end
  endtask

  task automatic drv0(input logic v, input logic lk, input logic [3:0] we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = v; req0_lock = lk; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drv1(input logic v, input logic lk, input logic [3:0] we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = v; req1_lock = lk; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, 4'h0, '0, '0);
    drv1(1'b0, 1'b0, 4'h0, '0, '0);
  endtask

  task automatic settle(); @(negedge clk); model_step(); endtask
  task automatic adv();    @(posedge clk); #1; endtask
  task automatic step();   settle(); adv(); endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      bram_mem[i] = {4{8'(i)}};
      m_mem[i]    = {4{8'(i)}};
    end
    bram_mem[5] = 32'hDEADBEEF; m_mem[5] = 32'hDEADBEEF;
    bram_mem[9] = 32'hAAAAAAAA; m_mem[9] = 32'hAAAAAAAA;
    m_owner = -1; m_last = 1; m_rv = '0; m_rd = '0;
    do_reset();

    // Single read
    drv0(1'b1, 1'b0, 4'h0, 7'd5, 32'h0);
    settle();
    chk("r20_en",   64'(bram_en),   64'h1);
    chk("r20_addr", 64'(bram_addr), 64'h5);
    adv();
    idle();
    settle();
    chk("r20_rsp0_valid", 64'(rsp0_valid), 64'h1);
    chk("r20_rsp0_rdata", 64'(rsp0_rdata), 64'hDEADBEEF);
    chk("r20_rsp1_valid", 64'(rsp1_valid), 64'h0);
    adv();

    // Tie for 4 cycles
    do_reset();
    drv0(1'b1, 1'b0, 4'h0, 7'd1, 32'h0);
    drv1(1'b1, 1'b0, 4'h0, 7'd2, 32'h0);
    for (int i = 0; i < 4; i++) begin
      settle();
      g = req0_ready ? 0 : (req1_ready ? 1 : -1);
`ifdef BRAM_ARB_RR_EN
      chk($sformatf("r21_grant%0d", i), 64'(g), 64'(i % 2));
`else
      chk($sformatf("r21_grant%0d", i), 64'(g), 64'h0);
`endif
      adv();
    end
    idle();
    step();

    // Burst lock from req1 with req0 pending
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv1(1'b1, (k < 3), 4'hF, 7'(20 + k), 32'hB0000000 + 32'(k));
      if (k > 0) drv0(1'b1, 1'b0, 4'h0, 7'd40, 32'h0);
      settle();
      chk($sformatf("r22_beat%0d", k), 64'(req1_ready), 64'h1);
      chk($sformatf("r22_hold%0d", k), 64'(req0_ready), 64'h0);
      adv();
    end
    drv1(1'b0, 1'b0, 4'h0, '0, '0);
    settle();
    chk("r22_after", 64'(req0_ready), 64'h1);
    adv();

    // Lock survives the owner dropping valid
    drv0(1'b1, 1'b1, 4'h0, 7'd41, 32'h0);
    settle();
    chk("r12_lock", 64'(req0_ready), 64'h1);
    adv();
    drv0(1'b0, 1'b0, 4'h0, '0, '0);
    drv1(1'b1, 1'b0, 4'h0, 7'd20, 32'h0);
    settle();
    chk("r12_gap", 64'(req1_ready), 64'h0);
    adv();
    drv0(1'b1, 1'b0, 4'h0, 7'd41, 32'h0);
    settle();
    chk("r12_release", 64'(req0_ready), 64'h1);
    adv();
    drv0(1'b0, 1'b0, 4'h0, '0, '0);
    settle();
    chk("r12_other", 64'(req1_ready), 64'h1);
    adv();
    idle();
    settle();
    chk("r12_burst_data", 64'(rsp1_rdata), 64'hB0000000);
    adv();

    // Byte write then read-back, back to back
    do_reset();
    drv0(1'b1, 1'b0, 4'b0011, 7'd9, 32'h12345678);
    step();
    drv0(1'b1, 1'b0, 4'h0, 7'd9, 32'h0);
    settle();
    chk("r23_wr_valid", 64'(rsp0_valid), 64'h1);
    chk("r23_wr_rdata", 64'(rsp0_rdata), 64'h12345678);
    chk("r23_rd_ready", 64'(req0_ready), 64'h1);
    adv();
    idle();
    settle();
    chk("r23_rd_rdata", 64'(rsp0_rdata), 64'hAAAA5678);
    adv();

    // Reset with a locked read in flight
    drv1(1'b1, 1'b1, 4'h0, 7'd30, 32'h0);
    step();
    drv1(1'b1, 1'b1, 4'h0, 7'd31, 32'h0);
    settle();
    chk("r24_acc", 64'(req1_ready), 64'h1);
    adv();
    idle();
    rst_n = 1'b0;
    settle();
    chk("r24_no_rsp", 64'(rsp1_valid), 64'h0);
    adv();
    rst_n = 1'b1;
    drv1(1'b1, 1'b0, 4'h0, 7'd31, 32'h0);
    settle();
    chk("r24_first", 64'(req1_ready), 64'h1);
    adv();
    drv1(1'b0, 1'b0, 4'h0, '0, '0);
    drv0(1'b1, 1'b0, 4'h0, 7'd5, 32'h0);
    settle();
    chk("r24_idle",  64'(req0_ready), 64'h1);
    chk("r24_rdata", 64'(rsp1_rdata), 64'h1F1F1F1F);
    adv();

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 32; i++) begin
      drv0((i % 3) != 2, (i % 5) == 0, (i % 4 == 1) ? 4'(i) : 4'h0,
           7'(i * 3), 32'(i) * 32'h01020304);
      drv1((i % 4) != 0, (i % 7) == 3, (i % 3 == 0) ? 4'hF : 4'h0,
           7'(i * 5 + 1), 32'hC0DE0000 + 32'(i));
      step();
    end
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
